bcd_mod_counter: RTL and testbench

//  Parametrised multi-digit BCD modulo counter: next generation of the clock's hour/minute/second counters.

---
 rtl/clock_pkg.sv | 55 +++++
 rtl/bcd_digit_step.sv | 35 +++
 rtl/bcd_mod_counter.sv | 112 +++++++++++
 tb/tb_bcd_mod_counter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared BCD constants, digit type and helpers for the clock counters.
// Width-generic helpers work on a fixed-width vector and a digit count.
package clock_pkg;

  localparam int BCD_W   = 4;
  localparam int MAX_DIG = 8;
  localparam int MAX_W   = BCD_W * MAX_DIG;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  function automatic logic bcd_valid(bcd_digit_t d);
    return d <= 4'd9;
  endfunction

  function automatic logic bcd_all_valid(
    logic [MAX_W-1:0] v,
    int digits
  );
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIG; i++)
      if (i < digits)
        ok = ok & bcd_valid(v[i*BCD_W +: BCD_W]);
    return ok;
  endfunction

  function automatic int bcd_to_bin(
    logic [MAX_W-1:0] v,
    int digits
  );
    int acc;
    acc = 0;
    for (int i = MAX_DIG-1; i >= 0; i--)
      if (i < digits)
        acc = acc * 10 + int'(v[i*BCD_W +: BCD_W]);
    return acc;
  endfunction

  function automatic logic [MAX_W-1:0] bin_to_bcd(
    int v,
    int digits
  );
    logic [MAX_W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < MAX_DIG; i++)
      if (i < digits) begin
        r[i*BCD_W +: BCD_W] = BCD_W'(x % 10);
        x = x / 10;
      end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit incremented or decremented when c_i is set;
// c_o ripples the decimal carry (up) or borrow (down) to the next digit.
module bcd_digit_step
  import clock_pkg::*;
(
  input  bcd_digit_t d_i,
  input  logic       dir_i,
  input  logic       c_i,
  output bcd_digit_t q_o,
  output logic       c_o
);

  always_comb begin
    q_o = d_i;
    c_o = 1'b0;
    if (c_i) begin
      if (!dir_i) begin
        if (d_i >= 4'd9) begin
          q_o = 4'd0;
          c_o = 1'b1;
        end else begin
          q_o = d_i + 4'd1;
        end
      end else begin
        if (d_i == 4'd0) begin
          q_o = 4'd9;
          c_o = 1'b1;
        end else begin
          q_o = d_i - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_mod_counter.sv
// Multi-digit BCD modulo counter with masked, range-checked load
// and carry/borrow pulse for cascading clock stages.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int DIGITS    = 2,
  parameter int MAX_VAL   = 23,
  parameter int MIN_VAL   = 0,
  parameter int RESET_VAL = 0
) (
  input  logic                clk,
  input  logic                CR,
  input  logic                tick,
  input  logic                en,
  input  logic                dir,
  input  logic                load,
  input  logic [DIGITS-1:0]   load_mask,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                carry,
  output logic                load_err,
  output logic                at_max,
  output logic                at_min
);

  localparam int W = BCD_W * DIGITS;
  localparam logic [W-1:0] MAX_BCD = W'(bin_to_bcd(MAX_VAL, DIGITS));
  localparam logic [W-1:0] MIN_BCD = W'(bin_to_bcd(MIN_VAL, DIGITS));
  localparam logic [W-1:0] RST_BCD = W'(bin_to_bcd(RESET_VAL, DIGITS));

  if (!(MIN_VAL <= RESET_VAL && RESET_VAL <= MAX_VAL
        && MAX_VAL < 10**DIGITS && DIGITS <= MAX_DIG)) begin : g_bad_param
    $error("bcd_mod_counter: illegal MIN/RESET/MAX/DIGITS");
  end

  logic [W-1:0] value_q, value_d;
  logic         carry_q, carry_d;
  logic         err_q, err_d;

  logic [W-1:0]    merged, stepped;
  logic [DIGITS:0] c;
  int              cur_bin, mrg_bin;
  logic            cur_ok, mrg_ok, at_wrap;

  assign c[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign merged[i*BCD_W +: BCD_W] = load_mask[i]
      ? load_val[i*BCD_W +: BCD_W]
      : value_q[i*BCD_W +: BCD_W];

    bcd_digit_step u_step (
      .d_i   (value_q[i*BCD_W +: BCD_W]),
      .dir_i (dir),
      .c_i   (c[i]),
      .q_o   (stepped[i*BCD_W +: BCD_W]),
      .c_o   (c[i+1])
    );
  end

  // Range and equality are judged on the binary value of the digits.
  assign cur_bin = bcd_to_bin(MAX_W'(value_q), DIGITS);
  assign mrg_bin = bcd_to_bin(MAX_W'(merged), DIGITS);

  assign cur_ok = bcd_all_valid(MAX_W'(value_q), DIGITS)
    && cur_bin >= MIN_VAL && cur_bin <= MAX_VAL;
  assign mrg_ok = bcd_all_valid(MAX_W'(merged), DIGITS)
    && mrg_bin >= MIN_VAL && mrg_bin <= MAX_VAL;

  // Ripple-out of the top digit also marks the wrap point.
  assign at_wrap = dir
    ? (cur_bin == MIN_VAL || c[DIGITS])
    : (cur_bin == MAX_VAL || c[DIGITS]);

  always_comb begin
    value_d = value_q;
    carry_d = 1'b0;
    err_d   = 1'b0;
    if (load) begin
      if (mrg_ok) value_d = merged;
      else        err_d   = 1'b1;
    end else if (tick && en) begin
      if (!cur_ok) begin
        value_d = dir ? MAX_BCD : MIN_BCD;
      end else if (at_wrap) begin
        value_d = dir ? MAX_BCD : MIN_BCD;
        carry_d = 1'b1;
      end else begin
        value_d = stepped;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (CR) begin
      value_q <= RST_BCD;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign bcd_out  = value_q;
  assign carry    = carry_q;
  assign load_err = err_q;
  assign at_max   = cur_bin == MAX_VAL;
  assign at_min   = cur_bin == MIN_VAL;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: 00..23 and 1..12 instances against
// an arithmetic reference model, directed cases plus random traffic.
module tb_bcd_mod_counter;

  logic       clk;
  logic       CR, tick, en, dir, load;
  logic [1:0] load_mask;
  logic [7:0] load_val;

  logic [7:0] a_bcd, b_bcd;
  logic       a_carry, a_err, a_max, a_min;
  logic       b_carry, b_err, b_max, b_min;

  int checks;
  int errors;
  logic chk_on;

  logic [7:0] mA, mB;
  logic       cA, eA, cB, eB;

  bcd_mod_counter #(
    .DIGITS(2), .MAX_VAL(23), .MIN_VAL(0), .RESET_VAL(0)
  ) dut_a (
    .clk(clk), .CR(CR), .tick(tick), .en(en), .dir(dir),
    .load(load), .load_mask(load_mask), .load_val(load_val),
    .bcd_out(a_bcd), .carry(a_carry), .load_err(a_err),
    .at_max(a_max), .at_min(a_min)
  );

  bcd_mod_counter #(
    .DIGITS(2), .MAX_VAL(12), .MIN_VAL(1), .RESET_VAL(7)
  ) dut_b (
    .clk(clk), .CR(CR), .tick(tick), .en(en), .dir(dir),
    .load(load), .load_mask(load_mask), .load_val(load_val),
    .bcd_out(b_bcd), .carry(b_carry), .load_err(b_err),
    .at_max(b_max), .at_min(b_min)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bin2(logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd(int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  function automatic logic legal(logic [7:0] v, int mn, int mx);
    return v[7:4] <= 4'd9 && v[3:0] <= 4'd9
      && bin2(v) >= mn && bin2(v) <= mx;
  endfunction

  // Returns {carry, load_err, value} after one clock.
  function automatic logic [9:0] model_next(
    input logic [7:0] cur,
    input int mn, input int mx, input int rst,
    input logic cr, input logic ld, input logic [1:0] mk,
    input logic [7:0] lv, input logic tk, input logic e,
    input logic d
  );
    logic [7:0] mg;
    int b;
    mg[3:0] = mk[0] ? lv[3:0] : cur[3:0];
    mg[7:4] = mk[1] ? lv[7:4] : cur[7:4];
    b = bin2(cur);
    if (cr) return {2'b00, to_bcd(rst)};
    if (ld) begin
      if (legal(mg, mn, mx)) return {2'b00, mg};
      return {2'b01, cur};
    end
    if (tk && e) begin
      if (!legal(cur, mn, mx)) return {2'b00, to_bcd(d ? mx : mn)};
      if (!d) begin
        if (b == mx) return {2'b10, to_bcd(mn)};
        return {2'b00, to_bcd(b + 1)};
      end
      if (b == mn) return {2'b10, to_bcd(mx)};
      return {2'b00, to_bcd(b - 1)};
    end
    return {2'b00, cur};
  endfunction

  always @(posedge clk) begin
    {cA, eA, mA} = model_next(mA, 0, 23, 0, CR, load, load_mask,
                              load_val, tick, en, dir);
    {cB, eB, mB} = model_next(mB, 1, 12, 7, CR, load, load_mask,
                              load_val, tick, en, dir);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("A.bcd", 32'(a_bcd), 32'(mA));
      check("A.carry", 32'(a_carry), 32'(cA));
      check("A.err", 32'(a_err), 32'(eA));
      check("A.max", 32'(a_max), 32'(bin2(mA) == 23));
      check("A.min", 32'(a_min), 32'(bin2(mA) == 0));
      check("B.bcd", 32'(b_bcd), 32'(mB));
      check("B.carry", 32'(b_carry), 32'(cB));
      check("B.err", 32'(b_err), 32'(eB));
      check("B.max", 32'(b_max), 32'(bin2(mB) == 12));
      check("B.min", 32'(b_min), 32'(bin2(mB) == 1));
    end
  end

  task automatic cyc(input logic cr_v, input logic ld_v,
                     input logic [1:0] mk, input logic [7:0] lv,
                     input logic tk_v, input logic en_v,
                     input logic dir_v);
    CR = cr_v; load = ld_v; load_mask = mk; load_val = lv;
    tick = tk_v; en = en_v; dir = dir_v;
    @(negedge clk);
  endtask

  initial begin
    int ncar;
    logic [7:0] rv;
    checks = 0;
    errors = 0;
    chk_on = 1'b0;
    CR = 1'b1; tick = 1'b0; en = 1'b0; dir = 1'b0;
    load = 1'b0; load_mask = 2'b00; load_val = 8'h00;
    @(negedge clk);
    cyc(1, 0, 2'b00, 8'h00, 0, 0, 0);
    chk_on = 1'b1;
    check("reset.A", 32'(a_bcd), 32'h00);
    check("reset.B", 32'(b_bcd), 32'h07);

    ncar = 0;
    for (int i = 0; i < 24; i++) begin
      cyc(0, 0, 2'b00, 8'h00, 1, 1, 0);
      if (a_carry) ncar++;
      check("t1.carry", 32'(a_carry), 32'(i == 23));
    end
    check("t1.ncarry", 32'(ncar), 32'd1);
    check("t1.wrap", 32'(a_bcd), 32'h00);

    cyc(0, 0, 2'b00, 8'h00, 1, 1, 1);
    check("t2.down_wrap", 32'(a_bcd), 32'h23);
    check("t2.carry", 32'(a_carry), 32'd1);
    cyc(0, 0, 2'b00, 8'h00, 1, 1, 1);
    check("t2.down", 32'(a_bcd), 32'h22);
    check("t2.nocarry", 32'(a_carry), 32'd0);

    cyc(0, 1, 2'b11, 8'h19, 0, 1, 0);
    check("t3.load19", 32'(a_bcd), 32'h19);
    cyc(0, 1, 2'b11, 8'h24, 0, 1, 0);
    check("t3.hold24", 32'(a_bcd), 32'h19);
    check("t3.err24", 32'(a_err), 32'd1);
    cyc(0, 1, 2'b11, 8'h1A, 0, 1, 0);
    check("t3.err1A", 32'(a_err), 32'd1);

    cyc(0, 1, 2'b11, 8'h15, 0, 1, 0);
    cyc(0, 1, 2'b10, 8'h27, 0, 1, 0);
    check("t4.err25", 32'(a_err), 32'd1);
    check("t4.hold15", 32'(a_bcd), 32'h15);
    cyc(0, 1, 2'b11, 8'h13, 0, 1, 0);
    cyc(0, 1, 2'b10, 8'h27, 0, 1, 0);
    check("t4.merge23", 32'(a_bcd), 32'h23);
    check("t4.noerr", 32'(a_err), 32'd0);

    #2 force dut_a.value_q = 8'h3F;
    mA = 8'h3F;
    #1 release dut_a.value_q;
    #1 check("t5.forced", 32'(a_bcd), 32'h3F);
    cyc(0, 0, 2'b00, 8'h00, 1, 1, 0);
    check("t5.illegal_up", 32'(a_bcd), 32'h00);
    check("t5.nocarry", 32'(a_carry), 32'd0);
    cyc(0, 0, 2'b00, 8'h00, 1, 1, 0);
    cyc(0, 0, 2'b00, 8'h00, 1, 0, 0);
    check("t5.en_hold", 32'(a_bcd), 32'h01);
    cyc(0, 1, 2'b11, 8'h07, 1, 1, 0);
    check("t5.load_wins", 32'(a_bcd), 32'h07);
    check("t5.load_nocarry", 32'(a_carry), 32'd0);

    cyc(0, 1, 2'b11, 8'h12, 0, 1, 0);
    check("t6.load12", 32'(b_bcd), 32'h12);
    cyc(0, 0, 2'b00, 8'h00, 1, 1, 0);
    check("t6.up_wrap", 32'(b_bcd), 32'h01);
    check("t6.up_carry", 32'(b_carry), 32'd1);
    cyc(0, 0, 2'b00, 8'h00, 1, 1, 1);
    check("t6.dn_wrap", 32'(b_bcd), 32'h12);
    check("t6.dn_carry", 32'(b_carry), 32'd1);
    cyc(0, 0, 2'b00, 8'h00, 1, 1, 0);
    cyc(0, 0, 2'b00, 8'h00, 1, 1, 0);
    check("t6.count", 32'(b_bcd), 32'h02);
    cyc(1, 1, 2'b11, 8'h05, 1, 1, 0);
    check("t6.clear_B", 32'(b_bcd), 32'h07);
    check("t6.clear_A", 32'(a_bcd), 32'h00);
    check("t6.clear_err", 32'(b_err), 32'd0);

    for (int i = 0; i < 400; i++) begin
      rv[7:4] = 4'($urandom_range(0, 11));
      rv[3:0] = 4'($urandom_range(0, 11));
      cyc($urandom_range(0, 99) < 3,
          $urandom_range(0, 99) < 15,
          2'($urandom_range(0, 3)),
          rv,
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 99) < 80,
          $urandom_range(0, 1) == 1);
    end

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
